// File: rtl/uart_pkg.sv
// Shared UART types and header bit positions used by the frame assembler and the TX controller.
package uart_pkg;

    typedef enum logic [1:0] {
        S_HDR,
        S_PAYLOAD,
        S_HOLD
    } asm_state_t;

    localparam int unsigned STALL_BIT   = 14;
    localparam int unsigned UNSTALL_BIT = 13;
    localparam int unsigned RAW_BIT     = 2;

endpackage

// File: rtl/uart_frame_assembler_if.sv
// Byte-in / frame-out handshake bundle of the UART frame assembler.
interface uart_frame_assembler_if #(
    parameter int unsigned HEADER_SIZE  = 32,
    parameter int unsigned MESSAGE_SIZE = 512
) ();

    logic                    ll_valid_in;
    logic [7:0]              ll_byte_in;
    logic                    ll_ready_out;
    logic                    bdge_valid_out;
    logic                    ctrl_ready_in;
    logic [HEADER_SIZE-1:0]  header_out;
    logic [MESSAGE_SIZE-1:0] message_out;

    // Assembler side.
    modport master (
        input  ll_valid_in,
        input  ll_byte_in,
        input  ctrl_ready_in,
        output ll_ready_out,
        output bdge_valid_out,
        output header_out,
        output message_out
    );

    // Byte source / frame sink side.
    modport slave (
        output ll_valid_in,
        output ll_byte_in,
        output ctrl_ready_in,
        input  ll_ready_out,
        input  bdge_valid_out,
        input  header_out,
        input  message_out
    );

endinterface

// File: rtl/uart_idle_timer.sv
// Inter-byte idle counter; expire_out flags the cycle on which TIMEOUT_CYCLES idle clocks have elapsed.
module uart_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic run_in,
    input  logic kick_in,
    output logic expire_out
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_q;
    logic [IDLE_W-1:0] idle_d;

    // Expiry does not wait for the kick: a byte on the expiry cycle still starts a new frame.
    assign expire_out = run_in && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        idle_d = idle_q + IDLE_W'(1);
        if (kick_in || expire_out || !run_in) begin
            idle_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

endmodule

// File: rtl/uart_frame_assembler.sv
// Packs the uart_rx byte stream MSB-first into {header, message}, consumes peer STALL/UNSTALL
// control headers and drops partial frames after an inter-byte timeout.
module uart_frame_assembler
    import uart_pkg::*;
#(
    parameter int unsigned MESSAGE_SIZE   = 512,
    parameter int unsigned HEADER_SIZE    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    uart_frame_assembler_if.master bus_if,
    output logic                   peer_stall_out,
    output logic                   timeout_err_out,
    output logic                   frame_err_out,
    output logic [7:0]             err_count_out
);

    localparam int unsigned W         = HEADER_SIZE + MESSAGE_SIZE;
    localparam int unsigned HDR_BYTES = HEADER_SIZE / 8;
    localparam int unsigned TOT_BYTES = W / 8;
    localparam int unsigned CNT_W     = $clog2(TOT_BYTES + 1);

    asm_state_t        state_q;
    asm_state_t        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [W-1:0]      sr_q;
    logic [W-1:0]      sr_d;

    logic              ready_q;
    logic              ready_d;
    logic              valid_q;
    logic              valid_d;
    logic              stall_q;
    logic              stall_d;
    logic              tout_q;
    logic              tout_d;
    logic              ferr_q;
    logic              ferr_d;
    logic [7:0]        errcnt_q;
    logic [7:0]        errcnt_d;

    logic              accept_c;
    logic              run_c;
    logic              expire_c;
    logic              hdr_last_c;
    logic              stall_bit_c;
    logic              unstall_bit_c;

    assign accept_c = bus_if.ll_valid_in && ready_q;
    assign run_c    = (state_q != S_HOLD) && (cnt_q != '0);

    uart_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .run_in     (run_c),
        .kick_in    (accept_c),
        .expire_out (expire_c)
    );

    // On the final header byte the earlier header bytes sit in the low end of the shift register,
    // so header bit b (b >= 8) is sr_q[b-8] while the incoming byte supplies bits [7:0].
    assign stall_bit_c   = sr_q[STALL_BIT - 8];
    assign unstall_bit_c = sr_q[UNSTALL_BIT - 8];
    assign hdr_last_c    = (state_q == S_HDR) && accept_c && !expire_c &&
                           (cnt_q == CNT_W'(HDR_BYTES - 1));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_HDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_HDR: begin
                if (expire_c) begin
                    cnt_d = accept_c ? CNT_W'(1) : '0;
                end else if (accept_c) begin
                    if (cnt_q == CNT_W'(HDR_BYTES - 1)) begin
                        if (stall_bit_c || unstall_bit_c) begin
                            cnt_d = '0;
                        end else begin
                            state_d = S_PAYLOAD;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PAYLOAD: begin
                if (expire_c) begin
                    state_d = S_HDR;
                    cnt_d   = accept_c ? CNT_W'(1) : '0;
                end else if (accept_c) begin
                    if (cnt_q == CNT_W'(TOT_BYTES - 1)) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (valid_q && bus_if.ctrl_ready_in) begin
                    state_d = S_HDR;
                end
            end
            default: begin
                state_d = S_HDR;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ready_d  = (state_d != S_HOLD);
        valid_d  = (state_d == S_HOLD);
        stall_d  = stall_q;
        ferr_d   = hdr_last_c && stall_bit_c && unstall_bit_c;
        tout_d   = expire_c;
        errcnt_d = errcnt_q;
        if (hdr_last_c && stall_bit_c && !unstall_bit_c) begin
            stall_d = 1'b1;
        end else if (hdr_last_c && unstall_bit_c && !stall_bit_c) begin
            stall_d = 1'b0;
        end
        if ((ferr_d || tout_d) && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            stall_q  <= 1'b0;
            tout_q   <= 1'b0;
            ferr_q   <= 1'b0;
            errcnt_q <= 8'd0;
        end else begin
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            stall_q  <= stall_d;
            tout_q   <= tout_d;
            ferr_q   <= ferr_d;
            errcnt_q <= errcnt_d;
        end
    end

    // Single frame shift register; frozen in S_HOLD because no byte is accepted there.
    always_comb begin
        sr_d = sr_q;
        if (accept_c) begin
            sr_d = {sr_q[W-9:0], bus_if.ll_byte_in};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bus_if.ll_ready_out   = ready_q;
    assign bus_if.bdge_valid_out = valid_q;
    assign bus_if.header_out     = sr_q[W-1 -: HEADER_SIZE];
    assign bus_if.message_out    = sr_q[MESSAGE_SIZE-1:0];
    assign peer_stall_out        = stall_q;
    assign timeout_err_out       = tout_q;
    assign frame_err_out         = ferr_q;
    assign err_count_out         = errcnt_q;

endmodule
